seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Sequential driver for the 8-digit, active-low 7-segment display on the board.
- Stores eight 4-bit hex digits written by upstream logic.
- Time-multiplexes them onto one shared active-low segment bus (A..G) and eight active-low anodes (AN0..AN7) at a programmable refresh rate.
- Replaces manual switch-based anode selection with an automatic scan. Decodes each digit internally with the standard hex glyph table.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range >= 2.
- CNT_W, 17, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  digit write strobe, sampled at clk rise.
- wr_addr  input  3  digit index to write (0 = rightmost, AN0).
- wr_data  input  4  hex value to store.
- digit_en  input  8  per-digit enable; 0 blanks that digit.
- A, B, C, D, E, F, G  output  1 each  segment drives, active-low (0 = lit).
- AN0..AN7  output  1 each  anode drives, active-low, at most one low at a time.
- scan_idx  output  3  index of the digit currently driven on the outputs.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset (async assert, applied immediately):
  - digit memory all 0, refresh counter 0, idx 0.
  - AN0..AN7 = 1, A..G = 1 (blank), scan_idx = 0, frame_tick = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and idx increments mod 8 (7 -> 0).
- frame_tick: registered, high for exactly the cycle after idx wraps 7 -> 0.
- Output pipeline:
  - Outputs are registered and lag idx by exactly one cycle.
  - Each cycle the output registers load the anode one-hot-low of idx and decode(mem[idx]), with mem read combinationally from current contents.
  - scan_idx is the registered copy of idx and stays aligned with the anodes.
- Write:
  - wr_en = 1 at edge t writes mem[wr_addr] = wr_data at edge t.
  - If wr_addr == idx, the new glyph appears at edge t+1.
  - Writes never stall or disturb the scan.
  - Consecutive writes to the same address: last write wins.
  - Write on the same edge as idx advance: memory updates, no conflict; the new digit shows the written value if addressed.
- Blanking: if digit_en[idx] = 0, the output registers load all anodes = 1 and A..G = 1. The scan still spends its full slot on that index, so brightness of the other digits is unchanged.
- Decode:
  - Standard hex, active-low, A = MSB of the segment group.
  - Glyph table: 0 -> ABCDEFG = 0000001, 1 -> 1001111, 2 -> 0010010, 3 -> 0000110, 4 -> 1001100, 5 -> 0100100, 6 -> 0100000, 7 -> 0001111, 8 -> 0000000, 9 -> 0000100, A -> 0001000, b -> 1100000, C -> 0110001, d -> 1000010, E -> 0110000, F -> 0111000.
- Invariants:
  - Never more than one anode low in any cycle.
  - No X on outputs after reset.
- Reset mid-scan: immediate return to reset values; stored digits are lost. After release, the scan restarts at digit 0 with a full REFRESH_DIV slot.

Test Plan:
- Reset behaviour, REFRESH_DIV = 4: assert reset mid-scan -> immediately AN0..AN7 = 11111111, A..G = 1111111, frame_tick = 0. After release, the first edge gives AN0 = 0 and glyph 0 = 0000001.
- Scan timing and frame pulse: write digits 0..7 = 0..7, digit_en = FF -> each anode is low for exactly 4 cycles in order AN0..AN7. scan_idx matches the active anode, and frame_tick pulses once every 32 cycles on return to AN0.
- Full glyph table: sweep wr_data 0..F into digit 0 -> A..G match the table exactly, e.g. 8 -> 0000000 and F -> 0111000.
- Blanking: digit_en = 8'b1111_1011 -> during the digit-2 slot all anodes = 1 and A..G = 1111111. The slot still lasts 4 cycles, and the other digits are unaffected.
- Write to the live digit: while digit 3 is active, write wr_addr = 3, wr_data = A -> the next edge shows 0001000. A write to addr 5 in the same slot does not alter the digit-3 outputs.
- Invariant check, random writes, enables and resets over 10k cycles -> never more than one anode low, and frame_tick is never high for two consecutive cycles.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: groups the digit write port, the enables and the display drives
// Ports: i_wr_en/i_wr_addr/i_wr_data digit write, i_digit_en per-digit enable,
//        o_seg {A..G} active-low segments, o_an[n] active-low anode n,
//        o_scan_idx digit on display, o_frame_tick one-cycle pulse when the scan is back at digit 0
interface seven_seg_scanner_if;
  logic       i_wr_en;
  logic [2:0] i_wr_addr;
  logic [3:0] i_wr_data;
  logic [7:0] i_digit_en;
  logic [6:0] o_seg;
  logic [7:0] o_an;
  logic [2:0] o_scan_idx;
  logic       o_frame_tick;
  modport master (output i_wr_en, i_wr_addr, i_wr_data, i_digit_en,
                  input  o_seg, o_an, o_scan_idx, o_frame_tick);
  modport slave  (input  i_wr_en, i_wr_addr, i_wr_data, i_digit_en,
                  output o_seg, o_an, o_scan_idx, o_frame_tick);
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: stores eight hex digits and time-multiplexes them onto an active-low 8-digit display
// Ports: clk rising-edge clock, reset async active-high, bus (slave) write port / enables / display drives
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input logic             clk,
  input logic             reset,
  seven_seg_scanner_if.slave bus
);
  logic [3:0]       r_mem [8];
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [6:0]       r_seg;
  logic [7:0]       r_an;
  logic [2:0]       r_scan_idx;
  logic             r_frame_tick;
  logic             w_wrap;
  logic             w_en;
  logic [6:0]       w_glyph;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    w_wrap  = r_cnt == CNT_W'(REFRESH_DIV - 1);
    w_en    = bus.i_digit_en[r_idx];
    w_glyph = decode(r_mem[r_idx]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_seg        <= '1;
      r_an         <= '1;
      r_scan_idx   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      if (bus.i_wr_en) r_mem[bus.i_wr_addr] <= bus.i_wr_data;
      r_cnt        <= w_wrap ? '0 : r_cnt + 1'b1;
      r_idx        <= w_wrap ? r_idx + 3'd1 : r_idx;
      r_an         <= w_en ? ~(8'd1 << r_idx) : 8'hFF;
      r_seg        <= w_en ? w_glyph : 7'h7F;
      r_scan_idx   <= r_idx;
      // idx at 0 while the displayed index is still 7 marks the first cycle after the wrap
      r_frame_tick <= (r_idx == 3'd0) && (r_scan_idx == 3'd7);
    end
  end

  assign bus.o_seg        = r_seg;
  assign bus.o_an         = r_an;
  assign bus.o_scan_idx   = r_scan_idx;
  assign bus.o_frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner with REFRESH_DIV = 4
module tb_seven_seg_scanner;
  localparam int DIV = 4;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] scan;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  seven_seg_scanner_if bus ();
  seven_seg_scanner #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [6:0] glyph [16];
  logic [3:0] m_mem [8];
  int         m_cnt, m_idx;
  logic       m_pend, prev_tick;
  exp_t       q [$];
  int         errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    e.an   = bus.i_digit_en[m_idx] ? ~(8'd1 << m_idx) : 8'hFF;
    e.seg  = bus.i_digit_en[m_idx] ? glyph[m_mem[m_idx]] : 7'h7F;
    e.scan = 3'(m_idx);
    e.tick = m_pend;
    m_pend = 1'b0;
    q.push_back(e);
    if (bus.i_wr_en) m_mem[bus.i_wr_addr] = bus.i_wr_data;
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      if (m_idx == 7) m_pend = 1'b1;
      m_idx = (m_idx + 1) % 8;
    end else m_cnt++;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("an", 32'(bus.o_an), 32'(e.an));
    chk("seg", 32'(bus.o_seg), 32'(e.seg));
    chk("scan_idx", 32'(bus.o_scan_idx), 32'(e.scan));
    chk("frame_tick", 32'(bus.o_frame_tick), 32'(e.tick));
    chk("onehot_an", 32'($onehot0(~bus.o_an)), 32'd1);
    chk("tick_twice", 32'(bus.o_frame_tick && prev_tick), 32'd0);
    prev_tick = bus.o_frame_tick;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_an", 32'(bus.o_an), 32'hFF);
    chk("rst_seg", 32'(bus.o_seg), 32'h7F);
    chk("rst_tick", 32'(bus.o_frame_tick), 32'd0);
    chk("rst_scan", 32'(bus.o_scan_idx), 32'd0);
    for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
    m_cnt = 0;
    m_idx = 0;
    m_pend = 1'b0;
    prev_tick = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    bus.i_wr_en = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    bus.i_digit_en = 8'hFF;
    @(posedge clk);
    #1;
    do_reset();
    step();
    chk("first_an", 32'(bus.o_an), 32'hFE);
    chk("first_seg", 32'(bus.o_seg), 32'h01);
    for (int i = 0; i < 8; i++) begin
      bus.i_wr_en = 1'b1;
      bus.i_wr_addr = 3'(i);
      bus.i_wr_data = 4'(i);
      step();
    end
    bus.i_wr_en = 1'b0;
    for (int i = 0; i < 70; i++) step();
    do_reset();
    for (int v = 0; v < 16; v++) begin
      bus.i_wr_en = 1'b1;
      bus.i_wr_addr = 3'd0;
      bus.i_wr_data = 4'(v);
      step();
      bus.i_wr_en = 1'b0;
      for (int i = 0; i < 32; i++) step();
    end
    bus.i_digit_en = 8'b1111_1011;
    for (int i = 0; i < 40; i++) step();
    bus.i_digit_en = 8'hFF;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
        if (m_idx == 3 && m_cnt == 0) found = 1'b1;
        else step();
      end
      chk("live_wait", 32'(found), 32'd1);
    end
    bus.i_wr_en = 1'b1;
    bus.i_wr_addr = 3'd3;
    bus.i_wr_data = 4'hA;
    step();
    bus.i_wr_addr = 3'd5;
    bus.i_wr_data = 4'h1;
    step();
    chk("live_glyph", 32'(bus.o_seg), 32'(7'b0001000));
    bus.i_wr_en = 1'b0;
    step();
    chk("live_keep", 32'(bus.o_seg), 32'(7'b0001000));
    for (int i = 0; i < 40; i++) step();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      bus.i_wr_en = 1'($urandom_range(0, 1));
      bus.i_wr_addr = 3'($urandom_range(0, 7));
      bus.i_wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.i_digit_en = 8'($urandom_range(0, 255));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
